// File: rtl/cluster_pkg.sv
// Shared cluster definitions: the instruction address type and the default processor count.
// The processor and the cluster top level use the same definitions.
package cluster_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned N_PROC_DEFAULT = 4;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/spawn_fifo.sv
// Start-address FIFO for the spawn dispatcher. Reset can optionally preload one entry.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (taken when not full, or when full and popping)
//   push_data   address to enqueue
//   pop         drop the head entry (ignored when empty)
//   head        oldest entry, valid when empty is low
//   full        all DEPTH entries in use
//   empty       no entries in use
//   level       occupancy, 0..DEPTH
module spawn_fifo
    import cluster_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter addr_t       PRELOAD_VALUE = 8'h00,
    parameter bit          PRELOAD_EN    = 1'b1,
    localparam int unsigned PTR_W        = $clog2(DEPTH),
    localparam int unsigned LVL_W        = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  addr_t            push_data,
    input  logic             pop,
    output addr_t            head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    addr_t            mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            if (PRELOAD_EN) begin
                mem_q[0] <= PRELOAD_VALUE;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= PTR_W'(PRELOAD_EN);
            count_q  <= LVL_W'(PRELOAD_EN);
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spawn_dispatcher.sv
// Cluster scheduler: accepts SPAWN requests over per-processor toggle handshakes, queues the
// start addresses and launches each one on the lowest-index idle processor. Reset preloads
// the boot address so processor 0 is launched first.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   trigger_spawn  per-processor request toggle (pending while != disp_ack)
//   spawn_addr     per-processor requested start address
//   disp_ack       per-processor acknowledge toggle
//   run            per-processor running flag
//   start          one-cycle launch pulse, at most one bit set
//   start_addr     per-processor launch address, held between pulses
//   queue_level    FIFO occupancy
//   cluster_idle   no request, no queued entry, no launch in flight, nothing running
module spawn_dispatcher
    import cluster_pkg::*;
#(
    parameter int unsigned  N_PROC      = N_PROC_DEFAULT,
    parameter int unsigned  QUEUE_DEPTH = 4,
    parameter addr_t        BOOT_ADDR   = 8'h00,
    localparam int unsigned LVL_W       = $clog2(QUEUE_DEPTH) + 1,
    localparam int unsigned IDX_W       = $clog2(N_PROC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PROC-1:0]       trigger_spawn,
    input  addr_t [N_PROC-1:0]      spawn_addr,
    output logic [N_PROC-1:0]       disp_ack,
    input  logic [N_PROC-1:0]       run,
    output logic [N_PROC-1:0]       start,
    output addr_t [N_PROC-1:0]      start_addr,
    output logic [LVL_W-1:0]        queue_level,
    output logic                    cluster_idle
);

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [N_PROC-1:0] launched_q;
    logic [N_PROC-1:0] pending;
    logic [N_PROC-1:0] avail;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  grant_cand;
    logic              launch_valid;
    logic              launch_any;
    logic [IDX_W-1:0]  launch_idx;
    logic [IDX_W-1:0]  launch_cand;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    addr_t             fifo_head;
    logic              idle_now;

    assign pending = trigger_spawn ^ disp_ack;
    // launched_q covers the gap between the START pulse and RUN rising.
    assign avail   = ~run & ~launched_q;

    // Round-robin: first pending request at or after rr_ptr_q, wrapping at N_PROC.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_cand  = rr_ptr_q;
        for (int unsigned k = 0; k < N_PROC; k++) begin
            if (!grant_valid && pending[grant_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = grant_cand;
            end
            grant_cand = (grant_cand == IDX_W'(N_PROC - 1)) ? '0 : grant_cand + 1'b1;
        end
    end

    // Lowest-index available processor.
    always_comb begin
        launch_any  = 1'b0;
        launch_idx  = '0;
        launch_cand = '0;
        for (int unsigned k = 0; k < N_PROC; k++) begin
            if (!launch_any && avail[launch_cand]) begin
                launch_any = 1'b1;
                launch_idx = launch_cand;
            end
            launch_cand = launch_cand + 1'b1;
        end
    end

    // The head is only launched from storage, so a fresh push cannot launch in its own cycle.
    assign launch_valid = launch_any & ~fifo_empty;
    assign accept       = grant_valid & (~fifo_full | launch_valid);
    assign idle_now     = ~|pending & fifo_empty & ~|launched_q & ~|start & ~|run;

    spawn_fifo #(
        .DEPTH         (QUEUE_DEPTH),
        .PRELOAD_VALUE (BOOT_ADDR),
        .PRELOAD_EN    (1'b1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (spawn_addr[grant_idx]),
        .pop       (launch_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (queue_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_ack     <= '0;
            start        <= '0;
            start_addr   <= '0;
            cluster_idle <= 1'b0;
            rr_ptr_q     <= '0;
            launched_q   <= '0;
        end else begin
            start        <= '0;
            launched_q   <= launched_q & ~run;
            cluster_idle <= idle_now;
            if (launch_valid) begin
                start[launch_idx]      <= 1'b1;
                start_addr[launch_idx] <= fifo_head;
                launched_q[launch_idx] <= 1'b1;
            end
            if (accept) begin
                disp_ack[grant_idx] <= trigger_spawn[grant_idx];
                rr_ptr_q <= (grant_idx == IDX_W'(N_PROC - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spawn_dispatcher.sv
// Bench for spawn_dispatcher: queue-based reference model compared every cycle, simple
// processor model (RUN rises the cycle after START), and directed literal checks.
module tb_spawn_dispatcher;
    import cluster_pkg::*;

    localparam int NP    = 4;
    localparam int DEPTH = 4;
    localparam addr_t BOOT = 8'h00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     trigger_spawn;
    addr_t [NP-1:0]    spawn_addr;
    logic [NP-1:0]     disp_ack;
    logic [NP-1:0]     run;
    logic [NP-1:0]     start;
    addr_t [NP-1:0]    start_addr;
    logic [2:0]        queue_level;
    logic              cluster_idle;

    // Processor model controls.
    logic [NP-1:0]     proc_en;
    logic [NP-1:0]     halt;
    logic [NP-1:0]     force_on;

    int n_cmp = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    // Reference model state.
    addr_t          m_q[$];
    logic [NP-1:0]  m_ack;
    logic [NP-1:0]  m_start;
    logic [NP-1:0]  m_launched;
    addr_t [NP-1:0] m_start_addr;
    logic           m_idle;
    int             m_ptr;

    spawn_dispatcher #(
        .N_PROC      (NP),
        .QUEUE_DEPTH (DEPTH),
        .BOOT_ADDR   (BOOT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trigger_spawn (trigger_spawn),
        .spawn_addr    (spawn_addr),
        .disp_ack      (disp_ack),
        .run           (run),
        .start         (start),
        .start_addr    (start_addr),
        .queue_level   (queue_level),
        .cluster_idle  (cluster_idle)
    );

    always #5 clk = ~clk;

    // Processor: samples START at the end of the pulse, so RUN rises one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= '0;
        else        run <= ((run | (start & proc_en)) & ~halt) | force_on;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = {};
        m_q.push_back(BOOT);
        m_ack = '0;
        m_start = '0;
        m_launched = '0;
        m_start_addr = '0;
        m_idle = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_step();
        logic [NP-1:0] pend;
        int win;
        int lnch;
        int c;
        logic nidle;
        logic take;
        pend  = trigger_spawn ^ m_ack;
        nidle = (pend == '0) && (m_q.size() == 0) && (m_launched == '0) &&
                (m_start == '0) && (run == '0);
        lnch = -1;
        if (m_q.size() != 0) begin
            for (int i = NP - 1; i >= 0; i--) if (!run[i] && !m_launched[i]) lnch = i;
        end
        win = -1;
        for (int k = NP - 1; k >= 0; k--) begin
            c = (m_ptr + k) % NP;
            if (pend[c]) win = c;
        end
        take = (win >= 0) && ((m_q.size() < DEPTH) || (lnch >= 0));
        m_launched = m_launched & ~run;
        m_start = '0;
        if (lnch >= 0) begin
            m_start[lnch] = 1'b1;
            m_start_addr[lnch] = m_q.pop_front();
            m_launched[lnch] = 1'b1;
        end
        if (take) begin
            m_q.push_back(spawn_addr[win]);
            m_ack[win] = trigger_spawn[win];
            m_ptr = (win + 1) % NP;
        end
        m_idle = nidle;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cyc_start", 32'(start), 32'(m_start));
            chk("cyc_start_addr", 32'(start_addr), 32'(m_start_addr));
            chk("cyc_disp_ack", 32'(disp_ack), 32'(m_ack));
            chk("cyc_level", 32'(queue_level), 32'(m_q.size()));
            chk("cyc_idle", 32'(cluster_idle), 32'(m_idle));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        rst_n = 1'b0;
        trigger_spawn = '0;
        spawn_addr = '0;
        proc_en = 4'b1101;
        halt = '0;
        force_on = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_start", 32'(start), 0);
        chk("rst_ack", 32'(disp_ack), 0);
        chk("rst_level", 32'(queue_level), 1);
        chk("rst_idle", 32'(cluster_idle), 0);
        chk("rst_start_addr", 32'(start_addr), 0);
        #2 rst_n = 1'b1;

        // Boot launch.
        @(negedge clk);
        chk("boot_start", 32'(start), 32'h1);
        chk("boot_addr", 32'(start_addr[0]), 32'(BOOT));
        chk("boot_level", 32'(queue_level), 0);
        @(negedge clk);
        chk("boot_pulse_one", 32'(start), 0);
        repeat (3) @(negedge clk);
        chk("boot_not_idle", 32'(cluster_idle), 0);

        // Single spawn from proc 0; proc 1 never raises RUN.
        spawn_addr[0] = 8'h40;
        trigger_spawn[0] = 1'b1;
        @(negedge clk);
        chk("spawn_ack", 32'(disp_ack), 32'h1);
        chk("spawn_level", 32'(queue_level), 1);
        chk("spawn_no_bypass", 32'(start), 0);
        @(negedge clk);
        chk("spawn_start", 32'(start), 32'h2);
        chk("spawn_addr1", 32'(start_addr[1]), 32'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_relaunch", 32'(start), 0);
        end

        // Fresh epoch: all processors busy, four simultaneous requests.
        #2 rst_n = 1'b0;
        trigger_spawn = '0;
        proc_en = 4'b1111;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reboot_start", 32'(start), 32'h1);
        force_on = 4'b1111;
        @(negedge clk);
        spawn_addr = {8'h50, 8'h30, 8'h20, 8'h10};
        trigger_spawn = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("burst_ack", 32'(disp_ack), (32'h1 << (k + 1)) - 1);
            chk("burst_level", 32'(queue_level), 32'(k + 1));
            chk("burst_no_start", 32'(start), 0);
        end

        // Full FIFO holds proc 1's new request until a launch frees a slot.
        spawn_addr[1] = 8'h77;
        trigger_spawn[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_hold_ack", 32'(disp_ack), 32'hF);
            chk("full_level", 32'(queue_level), 4);
        end
        halt = 4'b0100;
        force_on = 4'b1011;
        @(negedge clk);
        chk("full_wait_run", 32'(start), 0);
        @(negedge clk);
        chk("full_launch", 32'(start), 32'h4);
        chk("full_launch_addr", 32'(start_addr[2]), 32'h10);
        chk("full_accept", 32'(disp_ack), 32'hD);
        chk("full_level_kept", 32'(queue_level), 4);
        halt = '0;
        force_on = '0;

        // Drain: all halt for one cycle, then queued entries launch on procs 0..3 in order.
        repeat (2) @(negedge clk);
        halt = 4'b1111;
        @(negedge clk);
        halt = '0;
        @(negedge clk);
        chk("drain0", 32'(start), 32'h1);
        chk("drain0_addr", 32'(start_addr[0]), 32'h20);
        chk("drain0_level", 32'(queue_level), 3);
        @(negedge clk);
        chk("drain1", 32'(start), 32'h2);
        chk("drain1_addr", 32'(start_addr[1]), 32'h30);
        @(negedge clk);
        chk("drain2", 32'(start), 32'h4);
        chk("drain2_addr", 32'(start_addr[2]), 32'h50);
        @(negedge clk);
        chk("drain3", 32'(start), 32'h8);
        chk("drain3_addr", 32'(start_addr[3]), 32'h77);
        chk("drain3_level", 32'(queue_level), 0);
        repeat (3) @(negedge clk);
        halt = 4'b1111;
        @(negedge clk);
        halt = '0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            got = cluster_idle;
        end
        chk("idle_reached", 32'(got), 1);
        chk("idle_level", 32'(queue_level), 0);

        // New burst; pointer sits at 2 so procs 2 then 3 are acked first.
        spawn_addr = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        trigger_spawn = trigger_spawn ^ 4'b1111;
        @(negedge clk);
        chk("rr_ack2", 32'(disp_ack), 32'h9);
        @(negedge clk);
        chk("rr_ack3", 32'(disp_ack), 32'h1);
        chk("rr_launch", 32'(start), 32'h1);
        chk("rr_launch_addr", 32'(start_addr[0]), 32'hA3);

        // Asynchronous reset mid-burst.
        #2 rst_n = 1'b0;
        trigger_spawn = '0;
        #1;
        chk("async_start", 32'(start), 0);
        chk("async_ack", 32'(disp_ack), 0);
        chk("async_level", 32'(queue_level), 1);
        chk("async_idle", 32'(cluster_idle), 0);
        chk("async_start_addr", 32'(start_addr), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reboot2_start", 32'(start), 32'h1);
        chk("reboot2_addr", 32'(start_addr[0]), 32'(BOOT));
        chk("reboot2_level", 32'(queue_level), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
